// File: rtl/seg7_pkg.sv
// Seven-segment encoding shared by the display blocks: active-low {dp,g..a} codes and a blank code.
package seg7_pkg;

    typedef logic [7:0] seg_t;

    localparam seg_t SEG_BLANK = 8'hFF;

    localparam seg_t SEG_TABLE [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    function automatic seg_t hex_to_seg(input logic [3:0] nib);
        return SEG_TABLE[nib];
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Synchronises and debounces an active-low push-button; emits a one-cycle pulse on each accepted press.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic pressed,
    output logic press_pulse
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             key_level;
    logic             pressed_q, pressed_d;
    logic             pulse_q, pulse_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // sync_q[1] is the synchronised key_n; invert it so 1 means pressed.
    assign key_level = ~sync_q[1];

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        pressed_d = pressed_q;
        pulse_d   = 1'b0;
        cnt_d     = '0;
        if (key_level != pressed_q) begin
            if (cnt_q == CNT_LAST) begin
                pressed_d = key_level;
                pulse_d   = key_level;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= 2'b11;
            pressed_q <= 1'b0;
            pulse_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            // NOTE: state updates are non-blocking so every flop samples pre-edge values.
            sync_q    <= {sync_q[0], key_n};
            pressed_q <= pressed_d;
            pulse_q   <= pulse_d;
            cnt_q     <= cnt_d;
        end
    end

    assign pressed     = pressed_q;
    assign press_pulse = pulse_q;

endmodule

// File: rtl/display_pager.sv
// Pages through fixed 6-digit hex words plus a live switch page on HEX5..HEX0,
// stepped by a debounced key or a timed auto-scroll.
module display_pager
    import seg7_pkg::*;
#(
    parameter int                            NUM_CONST_PAGES = 2,
    parameter logic [NUM_CONST_PAGES*24-1:0] PAGE_DATA       = {24'h120997, 24'h071201},
    parameter int                            DEBOUNCE_CYCLES = 500000,
    parameter int                            DWELL_CYCLES    = 100000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_n,
    input  logic [9:0] sw,
    output logic [7:0] hex0,
    output logic [7:0] hex1,
    output logic [7:0] hex2,
    output logic [7:0] hex3,
    output logic [7:0] hex4,
    output logic [7:0] hex5,
    output logic [9:0] ledr
);

    localparam int NUM_PAGES = NUM_CONST_PAGES + 1;
    localparam int PAGE_W    = $clog2(NUM_PAGES);
    localparam int DWELL_W   = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [PAGE_W-1:0]  LAST_PAGE  = PAGE_W'(NUM_PAGES - 1);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);

    logic [PAGE_W-1:0]  page_q, page_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    seg_t [5:0]         digit_q, digit_d;
    logic [9:0]         ledr_q, ledr_d;
    logic               step, key_pressed, auto_en, dwell_tc, advance, lead;
    logic [23:0]        page_word;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_debounce (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_n      (key_n),
        .pressed    (key_pressed),
        .press_pulse(step)
    );

    // A step and a terminal count in the same cycle merge into one advance.
    assign auto_en  = sw[9];
    assign dwell_tc = auto_en && (dwell_q == DWELL_LAST);
    assign advance  = step || dwell_tc;

    always_comb begin
        page_d  = page_q;
        dwell_d = '0;
        if (advance) begin
            page_d = (page_q == LAST_PAGE) ? '0 : page_q + 1'b1;
        end
        if (auto_en && !advance) begin
            dwell_d = dwell_q + 1'b1;
        end
    end

    always_comb begin
        page_word = '0;
        for (int k = 0; k < NUM_CONST_PAGES; k++) begin
            if (page_q == PAGE_W'(k)) begin
                page_word = PAGE_DATA[24*k +: 24];
            end
        end
    end

    always_comb begin
        digit_d = {6{SEG_BLANK}};
        ledr_d  = {sw[9], key_pressed, 8'h00};
        lead    = 1'b0;
        if (page_q == LAST_PAGE) begin
            digit_d[1]  = hex_to_seg(sw[7:4]);
            digit_d[0]  = hex_to_seg(sw[3:0]);
            ledr_d[7:0] = sw[7:0];
        end else begin
            // lead stays set while only zeros have been seen from HEX5 down; HEX0 always shows.
            lead = sw[8];
            for (int n = 5; n >= 0; n--) begin
                lead       = lead && (page_word[4*n +: 4] == 4'h0) && (n != 0);
                digit_d[n] = lead ? SEG_BLANK : hex_to_seg(page_word[4*n +: 4]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            page_q  <= '0;
            dwell_q <= '0;
            digit_q <= {6{SEG_BLANK}};
            ledr_q  <= '0;
        end else begin
            page_q  <= page_d;
            dwell_q <= dwell_d;
            digit_q <= digit_d;
            ledr_q  <= ledr_d;
        end
    end

    assign hex0 = digit_q[0];
    assign hex1 = digit_q[1];
    assign hex2 = digit_q[2];
    assign hex3 = digit_q[3];
    assign hex4 = digit_q[4];
    assign hex5 = digit_q[5];
    assign ledr = ledr_q;

endmodule

// File: tb/tb_display_pager.sv
// Directed bench for display_pager with short debounce (4) and dwell (16) counts.
module tb_display_pager;

    logic       clk;
    logic       rst_n;
    logic       key_n;
    logic [9:0] sw;
    logic [7:0] hex0, hex1, hex2, hex3, hex4, hex5;
    logic [9:0] ledr;
    logic [47:0] hex_all;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [47:0] ALL_OFF = 48'hFFFF_FFFF_FFFF;
    localparam logic [47:0] P0      = {8'hC0, 8'hF8, 8'hF9, 8'hA4, 8'hC0, 8'hF9};
    localparam logic [47:0] P0_SUP  = {8'hFF, 8'hF8, 8'hF9, 8'hA4, 8'hC0, 8'hF9};
    localparam logic [47:0] P1      = {8'hF9, 8'hA4, 8'hC0, 8'h90, 8'h90, 8'hF8};
    localparam logic [47:0] LIVE_3C = {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hB0, 8'hC6};
    localparam logic [47:0] LIVE_00 = {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hC0, 8'hC0};

    display_pager #(
        .DEBOUNCE_CYCLES(4),
        .DWELL_CYCLES   (16)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .key_n(key_n),
        .sw   (sw),
        .hex0 (hex0),
        .hex1 (hex1),
        .hex2 (hex2),
        .hex3 (hex3),
        .hex4 (hex4),
        .hex5 (hex5),
        .ledr (ledr)
    );

    assign hex_all = {hex5, hex4, hex3, hex2, hex1, hex0};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic press(input int low_cycles);
        key_n = 1'b0;
        repeat (low_cycles) @(negedge clk);
        key_n = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        key_n = 1'b1;
        sw    = 10'h000;
        repeat (3) @(negedge clk);
        n_checks++;
        if (hex_all !== ALL_OFF) begin
            n_fail++;
            $display("FAIL reset_hex: got %h expected %h", hex_all, ALL_OFF);
        end
        n_checks++;
        if (ledr !== 10'h000) begin
            n_fail++;
            $display("FAIL reset_ledr: got %h expected %h", ledr, 10'h000);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (hex_all !== P0) begin
            n_fail++;
            $display("FAIL post_reset_page0: got %h expected %h", hex_all, P0);
        end
    endtask

    task automatic test_debounce;
        key_n = 1'b0;
        repeat (3) @(negedge clk);
        key_n = 1'b1;
        repeat (10) @(negedge clk);
        n_checks++;
        if (hex_all !== P0) begin
            n_fail++;
            $display("FAIL short_press_no_step: got %h expected %h", hex_all, P0);
        end
        key_n = 1'b0;
        repeat (10) @(negedge clk);
        n_checks++;
        if (hex_all !== P1) begin
            n_fail++;
            $display("FAIL long_press_step: got %h expected %h", hex_all, P1);
        end
        n_checks++;
        if (ledr !== 10'h100) begin
            n_fail++;
            $display("FAIL pressed_led: got %h expected %h", ledr, 10'h100);
        end
        key_n = 1'b1;
        repeat (12) @(negedge clk);
        n_checks++;
        if (hex_all !== P1) begin
            n_fail++;
            $display("FAIL release_no_step: got %h expected %h", hex_all, P1);
        end
    endtask

    task automatic test_live_page;
        press(10);
        sw = 10'h03C;
        @(negedge clk);
        n_checks++;
        if (hex_all !== LIVE_3C) begin
            n_fail++;
            $display("FAIL live_hex: got %h expected %h", hex_all, LIVE_3C);
        end
        n_checks++;
        if (ledr !== 10'h03C) begin
            n_fail++;
            $display("FAIL live_ledr: got %h expected %h", ledr, 10'h03C);
        end
        press(10);
        n_checks++;
        if (hex_all !== P0) begin
            n_fail++;
            $display("FAIL wrap_to_page0: got %h expected %h", hex_all, P0);
        end
        n_checks++;
        if (ledr !== 10'h000) begin
            n_fail++;
            $display("FAIL const_page_ledr: got %h expected %h", ledr, 10'h000);
        end
    endtask

    task automatic test_zero_suppress;
        sw = 10'h100;
        @(negedge clk);
        n_checks++;
        if (hex_all !== P0_SUP) begin
            n_fail++;
            $display("FAIL suppress_page0: got %h expected %h", hex_all, P0_SUP);
        end
        press(10);
        n_checks++;
        if (hex_all !== P1) begin
            n_fail++;
            $display("FAIL suppress_page1: got %h expected %h", hex_all, P1);
        end
        press(10);
        n_checks++;
        if (hex_all !== LIVE_00) begin
            n_fail++;
            $display("FAIL suppress_live_zero: got %h expected %h", hex_all, LIVE_00);
        end
        press(10);
        sw = 10'h000;
        @(negedge clk);
        n_checks++;
        if (hex_all !== P0) begin
            n_fail++;
            $display("FAIL suppress_off_page0: got %h expected %h", hex_all, P0);
        end
    endtask

    task automatic test_auto_scroll;
        sw = 10'h200;
        repeat (16) @(negedge clk);
        n_checks++;
        if (hex_all !== P0) begin
            n_fail++;
            $display("FAIL auto_before_first: got %h expected %h", hex_all, P0);
        end
        @(negedge clk);
        n_checks++;
        if (hex_all !== P1) begin
            n_fail++;
            $display("FAIL auto_first_advance: got %h expected %h", hex_all, P1);
        end
        repeat (15) @(negedge clk);
        n_checks++;
        if (hex_all !== P1) begin
            n_fail++;
            $display("FAIL auto_before_second: got %h expected %h", hex_all, P1);
        end
        @(negedge clk);
        n_checks++;
        if (hex_all !== LIVE_00) begin
            n_fail++;
            $display("FAIL auto_second_advance: got %h expected %h", hex_all, LIVE_00);
        end
        n_checks++;
        if (ledr !== 10'h200) begin
            n_fail++;
            $display("FAIL auto_ledr: got %h expected %h", ledr, 10'h200);
        end
        repeat (16) @(negedge clk);
        n_checks++;
        if (hex_all !== P0) begin
            n_fail++;
            $display("FAIL auto_wrap: got %h expected %h", hex_all, P0);
        end
        // Press timed so the accepted step lands on the next terminal-count cycle.
        repeat (8) @(negedge clk);
        key_n = 1'b0;
        repeat (6) @(negedge clk);
        key_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (hex_all !== P1) begin
            n_fail++;
            $display("FAIL step_on_terminal_single: got %h expected %h", hex_all, P1);
        end
        n_checks++;
        if (ledr !== 10'h300) begin
            n_fail++;
            $display("FAIL step_on_terminal_ledr: got %h expected %h", ledr, 10'h300);
        end
        repeat (15) @(negedge clk);
        n_checks++;
        if (hex_all !== P1) begin
            n_fail++;
            $display("FAIL after_coincide_hold: got %h expected %h", hex_all, P1);
        end
        @(negedge clk);
        n_checks++;
        if (hex_all !== LIVE_00) begin
            n_fail++;
            $display("FAIL after_coincide_advance: got %h expected %h", hex_all, LIVE_00);
        end
    endtask

    task automatic test_reset_midflight;
        key_n = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (hex_all !== ALL_OFF) begin
            n_fail++;
            $display("FAIL async_reset_hex: got %h expected %h", hex_all, ALL_OFF);
        end
        n_checks++;
        if (ledr !== 10'h000) begin
            n_fail++;
            $display("FAIL async_reset_ledr: got %h expected %h", ledr, 10'h000);
        end
        key_n = 1'b1;
        sw    = 10'h000;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        n_checks++;
        if (hex_all !== P0) begin
            n_fail++;
            $display("FAIL reset_release_page0: got %h expected %h", hex_all, P0);
        end
        n_checks++;
        if (ledr !== 10'h000) begin
            n_fail++;
            $display("FAIL reset_release_ledr: got %h expected %h", ledr, 10'h000);
        end
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_live_page();
        test_zero_suppress();
        test_auto_scroll();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
